// File: rtl/nmi_rx_pkg.sv
// Shared types and sizing helpers for the NMI receiver.
// Optional acknowledge timeout is enabled by defining NMI_RX_TIMEOUT_EN.
package nmi_rx_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      ASSERT   = 2'd1,
      WAIT_ACK = 2'd2
   } nmi_rx_state_t;

   // Tick counter must hold the larger of the two terminal counts.
   function automatic int unsigned cnt_width(input int unsigned hold, input int unsigned tmo);
      int unsigned m;
      m = (hold > tmo) ? hold : tmo;
      return $clog2(m + 1);
   endfunction

endpackage

// File: rtl/nmi_tick_counter.sv
// Clear/enable cpu_en tick counter with a terminal-count compare.
// Shared between the hold and acknowledge-wait phases of nmi_receiver.
module nmi_tick_counter #(
   parameter int unsigned W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_clr,
   input  logic         i_en,
   input  logic [W-1:0] i_term,
   output logic         o_tc_c
);

   logic [W-1:0] r_count;

   always_ff @(posedge clk) begin
      if (rst || i_clr) begin
         r_count <= '0;
      end else if (i_en) begin
         r_count <= r_count + W'(1);
      end
   end

   assign o_tc_c = (r_count == i_term);

endmodule

// File: rtl/nmi_receiver.sv
// Turns rising edges of the NMI request level into timed active-low nmi_n pulses.
// Define NMI_RX_TIMEOUT_EN to add the acknowledge timeout and sticky timeout_err.
import nmi_rx_pkg::*;

module nmi_receiver #(
   parameter int unsigned HOLD_TICKS    = 2,
   parameter int unsigned TIMEOUT_TICKS = 64,
   parameter int unsigned MISS_W        = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              nmi_in,
   input  logic              cpu_en,
   input  logic              vec_ack,
   input  logic              clr,
   output logic              nmi_n,
   output logic              busy,
   output logic              pending,
   output logic [MISS_W-1:0] miss_cnt,
   output logic              timeout_err
);

   localparam int unsigned CNT_W = cnt_width(HOLD_TICKS, TIMEOUT_TICKS);
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_TICKS - 1);
`ifdef NMI_RX_TIMEOUT_EN
   localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(TIMEOUT_TICKS - 1);
`endif

   nmi_rx_state_t     r_state;
   nmi_rx_state_t     w_state_nxt;
   logic              r_nmi_in_q;
   logic              r_nmi_n;
   logic              w_nmi_n_nxt;
   logic              r_busy;
   logic              r_pending;
   logic              w_pending_nxt;
   logic              r_ack_seen;
   logic              w_ack_seen_nxt;
   logic [MISS_W-1:0] r_miss_cnt;
   logic              w_miss;
   logic              w_rise;
   logic              w_cnt_clr;
   logic              w_cnt_en;
   logic [CNT_W-1:0]  w_term;
   logic              w_tc;
`ifdef NMI_RX_TIMEOUT_EN
   logic              r_timeout_err;
   logic              w_timeout;
`endif

   assign w_rise = nmi_in & ~r_nmi_in_q;

   // Counter restarts on every state change so each phase counts from zero.
   assign w_cnt_clr = (r_state == IDLE) | (w_state_nxt != r_state);
`ifdef NMI_RX_TIMEOUT_EN
   assign w_cnt_en  = cpu_en & (r_state != IDLE);
   assign w_term    = (r_state == WAIT_ACK) ? TMO_LAST : HOLD_LAST;
`else
   assign w_cnt_en  = cpu_en & (r_state == ASSERT);
   assign w_term    = HOLD_LAST;
`endif

   nmi_tick_counter #(.W(CNT_W)) u_tick (
      .clk    (clk),
      .rst    (rst),
      .i_clr  (w_cnt_clr),
      .i_en   (w_cnt_en),
      .i_term (w_term),
      .o_tc_c (w_tc)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= IDLE;
         r_nmi_in_q <= 1'b1;
         r_nmi_n    <= 1'b1;
         r_busy     <= 1'b0;
         r_pending  <= 1'b0;
         r_ack_seen <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_nmi_in_q <= nmi_in;
         r_nmi_n    <= w_nmi_n_nxt;
         r_busy     <= (w_state_nxt != IDLE);
         r_pending  <= w_pending_nxt;
         r_ack_seen <= w_ack_seen_nxt;
      end
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_nmi_n_nxt    = r_nmi_n;
      w_pending_nxt  = r_pending;
      w_ack_seen_nxt = r_ack_seen;
      w_miss         = 1'b0;
`ifdef NMI_RX_TIMEOUT_EN
      w_timeout      = 1'b0;
`endif
      case (r_state)
         IDLE: begin
            w_ack_seen_nxt = 1'b0;
            if (w_rise || r_pending) begin
               w_state_nxt   = ASSERT;
               w_nmi_n_nxt   = 1'b0;
               w_pending_nxt = w_rise & r_pending;
            end
         end
         ASSERT: begin
            if (vec_ack) w_ack_seen_nxt = 1'b1;
            // An ack already seen (or arriving now) skips the wait phase.
            if (cpu_en && w_tc) begin
               w_nmi_n_nxt    = 1'b1;
               w_ack_seen_nxt = 1'b0;
               w_state_nxt    = (r_ack_seen || vec_ack) ? IDLE : WAIT_ACK;
            end
         end
         WAIT_ACK: begin
            if (vec_ack) begin
               w_state_nxt = IDLE;
            end
`ifdef NMI_RX_TIMEOUT_EN
            else if (cpu_en && w_tc) begin
               w_timeout   = 1'b1;
               w_state_nxt = IDLE;
            end
`endif
         end
         default: w_state_nxt = IDLE;
      endcase
      if (w_rise && (r_state != IDLE)) begin
         if (!r_pending) w_pending_nxt = 1'b1;
         else            w_miss        = 1'b1;
      end
   end

   // A miss coinciding with clr still counts once.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_miss_cnt <= '0;
      end else if (clr) begin
         r_miss_cnt <= w_miss ? MISS_W'(1) : '0;
      end else if (w_miss && (r_miss_cnt != {MISS_W{1'b1}})) begin
         r_miss_cnt <= r_miss_cnt + MISS_W'(1);
      end
   end

`ifdef NMI_RX_TIMEOUT_EN
   always_ff @(posedge clk) begin
      if (rst)            r_timeout_err <= 1'b0;
      else if (w_timeout) r_timeout_err <= 1'b1;
      else if (clr)       r_timeout_err <= 1'b0;
   end
   assign timeout_err = r_timeout_err;
`else
   assign timeout_err = 1'b0;
`endif

   assign nmi_n    = r_nmi_n;
   assign busy     = r_busy;
   assign pending  = r_pending;
   assign miss_cnt = r_miss_cnt;

endmodule

// File: tb/tb_nmi_receiver.sv
// Self-checking bench for nmi_receiver: directed scenarios plus random traffic against a request-level model.
module tb_nmi_receiver;

   localparam int HOLD = 2;
   localparam int TMO  = 4;
   localparam int MW   = 2;
`ifdef NMI_RX_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          nmi_in = 1'b0;
   logic          cpu_en = 1'b0;
   logic          vec_ack = 1'b0;
   logic          clr = 1'b0;
   logic          nmi_n;
   logic          busy;
   logic          pending;
   logic [MW-1:0] miss_cnt;
   logic          timeout_err;

   int   errors = 0;
   int   checks = 0;
   int   cyc = 0;
   int   en_mode = 0;
   int   falls = 0;
   bit   ack_on_to = 1'b0;
   logic prev_n = 1'b1;

   // Reference model: phase 0 = no request in service, 1 = pulse low, 2 = awaiting ack.
   int m_phase;
   int m_ticks;
   int m_miss;
   bit m_early;
   bit m_q;
   bit m_terr;
   bit m_prev_in;
   bit m_nmi_n;

   always #5 clk = ~clk;

   nmi_receiver #(
      .HOLD_TICKS   (HOLD),
      .TIMEOUT_TICKS(TMO),
      .MISS_W       (MW)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .nmi_in     (nmi_in),
      .cpu_en     (cpu_en),
      .vec_ack    (vec_ack),
      .clr        (clr),
      .nmi_n      (nmi_n),
      .busy       (busy),
      .pending    (pending),
      .miss_cnt   (miss_cnt),
      .timeout_err(timeout_err)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic model_reset();
      m_phase = 0; m_ticks = 0; m_miss = 0; m_early = 0;
      m_q = 0; m_terr = 0; m_prev_in = 1; m_nmi_n = 1;
   endtask

   task automatic model_step();
      bit rise, old_q, to;
      int old_phase, inc;
      rise = nmi_in && !m_prev_in;
      if (rst) begin
         model_reset();
         return;
      end
      m_prev_in = nmi_in;
      old_q = m_q; old_phase = m_phase; inc = 0; to = 0;
      case (m_phase)
         0: if (rise || old_q) begin
               m_phase = 1; m_ticks = 0; m_early = 0; m_nmi_n = 0;
               m_q = rise && old_q;
            end
         1: begin
               if (vec_ack) m_early = 1;
               if (cpu_en) begin
                  m_ticks++;
                  if (m_ticks == HOLD) begin
                     m_nmi_n = 1; m_ticks = 0;
                     m_phase = m_early ? 0 : 2;
                  end
               end
            end
         default: begin
               if (vec_ack) m_phase = 0;
               else if (TO_EN && cpu_en) begin
                  m_ticks++;
                  if (m_ticks == TMO) begin to = 1; m_phase = 0; end
               end
            end
      endcase
      if (rise && old_phase != 0) begin
         if (!old_q) m_q = 1;
         else        inc = 1;
      end
      if (clr) m_miss = inc;
      else if (inc && m_miss < (1 << MW) - 1) m_miss++;
      if (to)       m_terr = 1;
      else if (clr) m_terr = 0;
   endtask

   task automatic compare_all();
      check_eq("nmi_n", nmi_n, m_nmi_n);
      check_eq("busy", busy, m_phase != 0);
      check_eq("pending", pending, m_q);
      check_eq("miss_cnt", miss_cnt, m_miss);
      check_eq("timeout_err", timeout_err, m_terr);
   endtask

   // One clock: choose cpu_en, clock, update model, compare, release strobes.
   task automatic tick();
      cyc++;
      case (en_mode)
         0:       cpu_en = (cyc % 4 == 0);
         1:       cpu_en = ($urandom_range(0, 2) == 0);
         default: cpu_en = 1'b0;
      endcase
      if (ack_on_to && m_phase == 2 && m_ticks == TMO - 1 && cpu_en) vec_ack = 1'b1;
      @(posedge clk);
      model_step();
      #1;
      compare_all();
      if (prev_n && !nmi_n) falls++;
      prev_n  = nmi_n;
      vec_ack = 1'b0;
      clr     = 1'b0;
   endtask

   task automatic run(input int n);
      repeat (n) tick();
   endtask

   task automatic rise_pulse();
      nmi_in = 1'b1; tick();
      nmi_in = 1'b0; tick();
   endtask

   initial begin
      int k;
      model_reset();
      rst = 1'b1; run(2);
      rst = 1'b0; run(3);

      // basic pulse
      en_mode = 0;
      nmi_in = 1'b1; tick();
      check_eq("rise_latency", nmi_n, 0);
      nmi_in = 1'b0;
      run(19);
      vec_ack = 1'b1; tick();
      check_eq("busy_after_ack", busy, 0);

      // level held high, then high through reset release
      falls = 0;
      nmi_in = 1'b1; run(30);
      vec_ack = 1'b1; run(70);
      check_eq("level_one_pulse", falls, 1);
      rst = 1'b1; run(2);
      rst = 1'b0; falls = 0; run(20);
      check_eq("no_pulse_after_rst", falls, 0);
      nmi_in = 1'b0; tick();

      // queue and miss during one WAIT_ACK
      clr = 1'b1; tick();
      nmi_in = 1'b1; tick(); nmi_in = 1'b0; run(12);
      en_mode = 2;
      rise_pulse();
      check_eq("pending_first", pending, 1);
      rise_pulse(); rise_pulse();
      check_eq("miss_two", miss_cnt, 2);
      vec_ack = 1'b1; tick(); tick();
      check_eq("queued_pulse", nmi_n, 0);
      en_mode = 0; run(12);
      vec_ack = 1'b1; tick(); run(2);

      // early ack during ASSERT
      en_mode = 2; run(2);
      nmi_in = 1'b1; tick(); nmi_in = 1'b0;
      vec_ack = 1'b1; tick();
      en_mode = 0; k = 0;
      while (nmi_n == 1'b0 && k < 20) begin tick(); k++; end
      check_eq("early_ack_hold_end", nmi_n, 1);
      check_eq("early_ack_idle", busy, 0);
      run(2);

      // saturation and clr with simultaneous miss
      clr = 1'b1; tick();
      nmi_in = 1'b1; tick(); nmi_in = 1'b0; run(12);
      en_mode = 2;
      repeat (6) rise_pulse();
      check_eq("miss_saturate", miss_cnt, 3);
      nmi_in = 1'b1; clr = 1'b1; tick(); nmi_in = 1'b0;
      check_eq("clr_with_miss", miss_cnt, 1);
      vec_ack = 1'b1; tick(); tick();
      en_mode = 0; run(12);
      vec_ack = 1'b1; tick(); run(2);

`ifdef NMI_RX_TIMEOUT_EN
      // acknowledge timeout, clear, and ack winning on the terminal tick
      nmi_in = 1'b1; tick(); nmi_in = 1'b0; run(40);
      check_eq("timeout_set", timeout_err, 1);
      check_eq("timeout_idle", busy, 0);
      clr = 1'b1; tick();
      check_eq("timeout_clr", timeout_err, 0);
      ack_on_to = 1'b1;
      nmi_in = 1'b1; tick(); nmi_in = 1'b0; run(40);
      ack_on_to = 1'b0;
      check_eq("ack_beats_timeout", timeout_err, 0);
      check_eq("ack_idle", busy, 0);
`endif

      // random traffic
      en_mode = 1;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 15) == 0) nmi_in = ~nmi_in;
         vec_ack = ($urandom_range(0, 11) == 0);
         clr     = ($urandom_range(0, 149) == 0);
         rst     = ($urandom_range(0, 399) == 0);
         tick();
      end
      rst = 1'b0;
      run(2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
